// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3 convolutional encoder and the Viterbi decoder.
// The generator constants here are also the ones the decoder's branch metric logic uses.
package viterbi_pkg;

    localparam int unsigned K = 3;

    // MSB taps the current bit, LSB the oldest register bit
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } enc_state_t;

    function automatic logic gen_parity(input logic [K-1:0] g, input logic [K-1:0] taps);
        return ^(g & taps);
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Handshake and symbol bus of the convolutional encoder.
// master drives the information bits; slave is the encoder.
interface conv_encoder_if;
    logic start;
    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_c0;
    logic out_c1;
    logic busy;
    logic frame_done;

    modport master (
        output start, in_valid, in_bit,
        input  in_ready, out_valid, out_c0, out_c1, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_bit,
        output in_ready, out_valid, out_c0, out_c1, busy, frame_done
    );
endinterface

// File: rtl/conv_enc_core.sv
// Encoder datapath: trellis shift register, generator parity and registered symbol output.
// One symbol is produced for every cycle load_en is high; clr zeroes the trellis state.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_en,
    input  logic u,
    input  logic clr,
    output logic c0,
    output logic c1,
    output logic valid
);

    logic [K-2:0] s_q;
    logic         c0_q;
    logic         c1_q;
    logic         valid_q;
    logic [K-1:0] taps;

    assign taps = {u, s_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q     <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= load_en;
            if (clr) begin
                s_q <= '0;
            end else if (load_en) begin
                s_q  <= {u, s_q[K-2:1]};
                c0_q <= gen_parity(G0, taps);
                c1_q <= gen_parity(G1, taps);
            end
        end
    end

    assign c0    = c0_q;
    assign c1    = c1_q;
    assign valid = valid_q;

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 framed convolutional encoder: FRAME_LEN data bits followed by two zero tail
// bits, so every frame ends in trellis state 0.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int unsigned  FRAME_LEN = 16,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF
) (
    input  logic           clk,
    input  logic           reset,
    conv_encoder_if.slave  bus
);

    localparam int unsigned     CW   = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]   LAST = CW'(FRAME_LEN - 1);

    enc_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          done_q, done_d;
    logic          accept;
    logic          load_en;
    logic          clr;
    logic          u;

    assign accept  = (state_q == DATA) && bus.in_valid;
    assign u       = (state_q == DATA) && bus.in_bit;
    assign load_en = accept || (state_q == FLUSH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                // done is registered so it lines up with the last tail symbol
                if (flush_q) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load_en (load_en),
        .u       (u),
        .clr     (clr),
        .c0      (bus.out_c0),
        .c1      (bus.out_c1),
        .valid   (bus.out_valid)
    );

    assign bus.in_ready   = (state_q == DATA);
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: symbol sequences, gaps, back-to-back frames, mid-frame
// reset, ignored stimulus and a single-bit frame.
module tb_conv_encoder;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    conv_encoder_if ifc ();
    conv_encoder_if ifc1 ();

    conv_encoder #(.FRAME_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    conv_encoder #(.FRAME_LEN(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] syms[$];
    int         done_at[$];
    int         done_alone = 0;
    logic [1:0] syms1[$];

    always @(negedge clk) begin
        if (ifc.out_valid) syms.push_back({ifc.out_c0, ifc.out_c1});
        if (ifc.frame_done) begin
            done_at.push_back(syms.size());
            if (!ifc.out_valid) done_alone++;
        end
        if (ifc1.out_valid) syms1.push_back({ifc1.out_c0, ifc1.out_c1});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        syms.delete();
        done_at.delete();
        done_alone = 0;
    endtask

    // Sends 4 bits MSB first with in_valid held, with an optional gap before the third bit.
    task automatic send_bits(input logic [3:0] b, input int gap);
        for (int i = 3; i >= 0; i--) begin
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    ifc.in_valid = 1'b0;
                    tick();
                    check_eq("gap_ready", {31'd0, ifc.in_ready}, 32'd1);
                    check_eq("gap_valid", {31'd0, ifc.out_valid}, 32'd0);
                end
            end
            ifc.in_valid = 1'b1;
            ifc.in_bit   = b[i];
            tick();
        end
        ifc.in_valid = 1'b0;
        ifc.in_bit   = 1'b0;
    endtask

    task automatic start_frame();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!ifc.frame_done && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, {31'd0, ifc.frame_done}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp, input int n);
        logic [31:0] obs = '0;
        for (int i = 0; i < syms.size() && i < 16; i++) obs = {obs[29:0], syms[i]};
        check_eq({tag, "_count"}, syms.size(), n);
        check_eq({tag, "_syms"}, obs, exp);
        check_eq({tag, "_done_pos"}, (done_at.size() == 1) ? done_at[0] : 0, n);
        check_eq({tag, "_done_alone"}, done_alone, 0);
    endtask

    localparam logic [31:0] EXP_1011 = 32'b11_10_00_01_01_11;

    initial begin
        ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_bit = 1'b0;
        ifc1.start = 1'b0; ifc1.in_valid = 1'b0; ifc1.in_bit = 1'b0;

        // reset state
        tick(); tick();
        check_eq("rst_outs", {26'd0, ifc.in_ready, ifc.out_valid, ifc.out_c0, ifc.out_c1,
                              ifc.busy, ifc.frame_done}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("idle_outs", {26'd0, ifc.in_ready, ifc.out_valid, ifc.out_c0, ifc.out_c1,
                               ifc.busy, ifc.frame_done}, 32'd0);

        // basic frame 1,0,1,1
        clear_mon();
        start_frame();
        check_eq("busy_rise", {31'd0, ifc.busy}, 32'd1);
        send_bits(4'b1011, 0);
        wait_done("f1");
        check_eq("f1_busy_fall", {31'd0, ifc.busy}, 32'd0);
        @(negedge clk); #1;
        check_frame("f1", EXP_1011, 6);
        check_eq("f1_state", {30'd0, dut.u_core.s_q}, 32'd0);

        // same frame with a 3-cycle gap between bits 2 and 3
        clear_mon();
        start_frame();
        send_bits(4'b1011, 3);
        wait_done("f2");
        @(negedge clk); #1;
        check_frame("f2", EXP_1011, 6);

        // back-to-back: start in the frame_done cycle, second frame all zeros
        clear_mon();
        start_frame();
        send_bits(4'b1011, 0);
        wait_done("f3a");
        ifc.start = 1'b1;
        @(negedge clk); #1;
        check_frame("f3a", EXP_1011, 6);
        clear_mon();
        tick();
        ifc.start = 1'b0;
        check_eq("f3_b2b_busy", {31'd0, ifc.busy}, 32'd1);
        send_bits(4'b0000, 0);
        wait_done("f3b");
        @(negedge clk); #1;
        check_frame("f3b", 32'd0, 6);

        // reset during the second data bit
        tick();
        clear_mon();
        start_frame();
        ifc.in_valid = 1'b1; ifc.in_bit = 1'b1;
        tick();
        ifc.in_bit = 1'b0;
        reset = 1'b1;
        tick();
        check_eq("mid_rst_outs", {26'd0, ifc.in_ready, ifc.out_valid, ifc.out_c0, ifc.out_c1,
                                  ifc.busy, ifc.frame_done}, 32'd0);
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        clear_mon();
        repeat (8) tick();
        check_eq("mid_rst_no_tail", syms.size(), 0);
        start_frame();
        send_bits(4'b1011, 0);
        wait_done("f4");
        @(negedge clk); #1;
        check_frame("f4", EXP_1011, 6);

        // in_valid in IDLE without start, then start/in_valid during FLUSH
        tick();
        clear_mon();
        ifc.in_valid = 1'b1; ifc.in_bit = 1'b1;
        tick(); tick();
        check_eq("idle_ready", {31'd0, ifc.in_ready}, 32'd0);
        check_eq("idle_busy", {31'd0, ifc.busy}, 32'd0);
        ifc.in_valid = 1'b0;
        tick();
        check_eq("idle_no_syms", syms.size(), 0);
        start_frame();
        send_bits(4'b1011, 0);
        ifc.start = 1'b1; ifc.in_valid = 1'b1; ifc.in_bit = 1'b1;
        tick(); tick();
        ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_bit = 1'b0;
        wait_done("f5");
        @(negedge clk); #1;
        repeat (3) tick();
        check_frame("f5", EXP_1011, 6);
        check_eq("f5_no_restart", {31'd0, ifc.busy}, 32'd0);

        // FRAME_LEN = 1, bit 1 -> 11,10,11
        syms1.delete();
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        ifc1.in_valid = 1'b1; ifc1.in_bit = 1'b1;
        tick();
        ifc1.in_valid = 1'b0; ifc1.in_bit = 1'b0;
        begin
            int n = 0;
            while (!ifc1.frame_done && n < 20) begin
                tick();
                n++;
            end
            check_eq("fl1_done_seen", {31'd0, ifc1.frame_done}, 32'd1);
        end
        @(negedge clk); #1;
        begin
            logic [31:0] obs = '0;
            for (int i = 0; i < syms1.size() && i < 16; i++) obs = {obs[29:0], syms1[i]};
            check_eq("fl1_count", syms1.size(), 3);
            check_eq("fl1_syms", obs, 32'b11_10_11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
